// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Shares the single register-file write port between two writeback sources:
// requester 0 (ALU/EX writeback) and requester 1 (memory-load writeback).
// Each requester feeds a small FIFO. A round-robin arbiter drains one FIFO
// head per cycle into the registered RegWrite/WriteRegister/WriteData port.
// Writes to ZERO_REG complete their handshake but are dropped. A requester is
// held off while the other FIFO holds a pending write to the same register,
// so all pending writes to one register sit in a single FIFO and FIFO order
// preserves write-after-write ordering.
//
// Optional build macro: REGWR_PENDING_EN
//   When defined, adds qry_addr/qry_pending so decode can ask whether a
//   register still has a write in flight.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   inX_valid/inX_ready   requester handshake (ready is combinational)
//   inX_addr/inX_data     destination register and write value
//   RegWrite              registered write enable to the register file
//   WriteRegister         registered write address
//   WriteData             registered write data
//   busy                  any FIFO non-empty or RegWrite high
//   qry_addr/qry_pending  (REGWR_PENDING_EN only) pending-write query
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [DATA_W-1:0] in1_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
`ifdef REGWR_PENDING_EN
  input  logic [ADDR_W-1:0] qry_addr,
  output logic              qry_pending,
`endif
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);

  // FIFO storage and bookkeeping, index [0] = requester 0, [1] = requester 1
  logic [ADDR_W-1:0] q_addr_r [2][DEPTH];
  logic [DATA_W-1:0] q_data_r [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r [2];
  logic [PTR_W-1:0]  rd_ptr_r [2];
  logic [CNT_W-1:0]  count_r  [2];
  logic              last_grant_r;

  logic [DEPTH-1:0]  slot_vld_s [2];
  logic [ADDR_W-1:0] push_addr_s [2];
  logic [DATA_W-1:0] push_data_s [2];
  logic [1:0]        full_s;
  logic [1:0]        nempty_s;
  logic [1:0]        push_s;
  logic [1:0]        pop_s;
  logic              hit0_s;
  logic              hit1_s;
  logic              tie_s;
  logic              grant_vld_s;
  logic              grant_sel_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  // Slot occupancy: slot i holds a live entry when its distance from the read
  // pointer (mod DEPTH) is below the entry count.
  always_comb begin : slot_occupancy
    logic [PTR_W-1:0] off_v;
    off_v = {PTR_W{1'b0}};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off_v            = PTR_W'(i) - rd_ptr_r[r];
        slot_vld_s[r][i] = ({1'b0, off_v} < count_r[r]);
      end
    end
  end

  // Cross-FIFO address match: inX_addr already pending in the other FIFO.
  // ZERO_REG is never enqueued, so it can never match here.
  always_comb begin
    hit0_s = 1'b0;
    hit1_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit0_s = hit0_s | (slot_vld_s[1][i] & (q_addr_r[1][i] == in0_addr));
      hit1_s = hit1_s | (slot_vld_s[0][i] & (q_addr_r[0][i] == in1_addr));
    end
  end

  // Occupancy flags and push requests for both FIFOs
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      full_s[r]   = (count_r[r] == FULL_C);
      nempty_s[r] = (count_r[r] != {CNT_W{1'b0}});
    end
    push_addr_s[0] = in0_addr;
    push_data_s[0] = in0_data;
    push_addr_s[1] = in1_addr;
    push_data_s[1] = in1_data;
    push_s[0]      = in0_valid & in0_ready & (in0_addr != ZERO_A);
    push_s[1]      = in1_valid & in1_ready & (in1_addr != ZERO_A);
  end

  // Ready uses pre-pop occupancy, so a full FIFO never pushes and pops at once.
  // On a same-cycle same-register collision requester 0 goes first.
  assign in0_ready = ~full_s[0] & ~hit0_s;
  assign tie_s     = in0_valid & in0_ready & (in0_addr == in1_addr) & (in1_addr != ZERO_A);
  assign in1_ready = ~full_s[1] & ~hit1_s & ~tie_s;

  // Round-robin arbitration over the two FIFO heads
  always_comb begin
    grant_vld_s = 1'b0;
    grant_sel_s = 1'b0;
    case (nempty_s)
      2'b01: begin
        grant_vld_s = 1'b1;
        grant_sel_s = 1'b0;
      end
      2'b10: begin
        grant_vld_s = 1'b1;
        grant_sel_s = 1'b1;
      end
      2'b11: begin
        grant_vld_s = 1'b1;
        grant_sel_s = ~last_grant_r;
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_sel_s = 1'b0;
      end
    endcase
  end

  assign pop_s[0]    = grant_vld_s & ~grant_sel_s;
  assign pop_s[1]    = grant_vld_s &  grant_sel_s;
  assign head_addr_s = q_addr_r[grant_sel_s][rd_ptr_r[grant_sel_s]];
  assign head_data_s = q_data_r[grant_sel_s][rd_ptr_r[grant_sel_s]];

  // FIFO storage, pointers and counts; pointers wrap naturally mod DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < DEPTH; i++) begin
          q_addr_r[r][i] <= {ADDR_W{1'b0}};
          q_data_r[r][i] <= {DATA_W{1'b0}};
        end
        wr_ptr_r[r] <= {PTR_W{1'b0}};
        rd_ptr_r[r] <= {PTR_W{1'b0}};
        count_r[r]  <= {CNT_W{1'b0}};
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push_s[r]) begin
          q_addr_r[r][wr_ptr_r[r]] <= push_addr_s[r];
          q_data_r[r][wr_ptr_r[r]] <= push_data_s[r];
          wr_ptr_r[r]              <= wr_ptr_r[r] + PTR_W'(1'b1);
        end
        if (pop_s[r]) begin
          rd_ptr_r[r] <= rd_ptr_r[r] + PTR_W'(1'b1);
        end
        case ({push_s[r], pop_s[r]})
          2'b10:   count_r[r] <= count_r[r] + CNT_W'(1'b1);
          2'b01:   count_r[r] <= count_r[r] - CNT_W'(1'b1);
          default: count_r[r] <= count_r[r];
        endcase
      end
    end
  end

  // Write-port output register; address/data hold when nothing is granted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= {ADDR_W{1'b0}};
      WriteData     <= {DATA_W{1'b0}};
      last_grant_r  <= 1'b1;
    end else begin
      RegWrite <= grant_vld_s;
      if (grant_vld_s) begin
        WriteRegister <= head_addr_s;
        WriteData     <= head_data_s;
        last_grant_r  <= grant_sel_s;
      end
    end
  end

  assign busy = nempty_s[0] | nempty_s[1] | RegWrite;

`ifdef REGWR_PENDING_EN
  // Pending-write query: any live FIFO entry or the write now on the port
  always_comb begin
    qry_pending = RegWrite & (WriteRegister == qry_addr);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        qry_pending = qry_pending | (slot_vld_s[r][i] & (q_addr_r[r][i] == qry_addr));
      end
    end
    qry_pending = qry_pending & (qry_addr != ZERO_A);
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wr_arbiter (default parameters). A queue-based
// reference model predicts ready, the write port and busy every cycle; an
// ideal register file built from accepted transfers is compared with the one
// written through the DUT port after the randomized phase.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int ZR    = 31;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in0_valid, in0_ready, in1_valid, in1_ready;
  logic [AW-1:0] in0_addr, in1_addr;
  logic [DW-1:0] in0_data, in1_data;
  logic          RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic          busy;
`ifdef REGWR_PENDING_EN
  logic [AW-1:0] qry_addr;
  logic          qry_pending;
`endif

  regfile_wr_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in0_valid    (in0_valid),
    .in0_ready    (in0_ready),
    .in0_addr     (in0_addr),
    .in0_data     (in0_data),
    .in1_valid    (in1_valid),
    .in1_ready    (in1_ready),
    .in1_addr     (in1_addr),
    .in1_data     (in1_data),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
`ifdef REGWR_PENDING_EN
    .qry_addr     (qry_addr),
    .qry_pending  (qry_pending),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model state
  ent_t          q0[$];
  ent_t          q1[$];
  bit            last_g;
  logic          m_rw;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  bit            tx0, tx1;

  logic [DW-1:0] rf_ideal [32];
  logic [DW-1:0] rf_dut   [32];
  logic [AW-1:0] got_a[$];
  logic [DW-1:0] got_d[$];
  int            got_t[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit has_addr(input ent_t q[$], input logic [AW-1:0] a);
    foreach (q[i]) if (q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    last_g = 1'b1;
    m_rw   = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after
  task automatic step();
    bit   r0, r1, g_ok, g;
    ent_t e;
    @(negedge clk);
    r0 = (q0.size() < DEPTH) && !has_addr(q1, in0_addr);
    r1 = (q1.size() < DEPTH) && !has_addr(q0, in1_addr) &&
         !(in0_valid && r0 && in0_addr == in1_addr && in1_addr != AW'(ZR));
    check("in0_ready", in0_ready, r0);
    check("in1_ready", in1_ready, r1);
`ifdef REGWR_PENDING_EN
    check("qry_pending", qry_pending, (qry_addr != AW'(ZR)) &&
          (has_addr(q0, qry_addr) || has_addr(q1, qry_addr) || (m_rw && m_wa == qry_addr)));
`endif
    tx0 = in0_valid && r0;
    tx1 = in1_valid && r1;
    @(posedge clk);
    #1;
    cyc++;
    g_ok = 1'b1;
    if (q0.size() > 0 && q1.size() > 0) g = ~last_g;
    else if (q0.size() > 0)             g = 1'b0;
    else if (q1.size() > 0)             g = 1'b1;
    else begin g_ok = 1'b0; g = 1'b0; end
    m_rw = g_ok;
    if (g_ok) begin
      if (g) e = q1.pop_front();
      else   e = q0.pop_front();
      m_wa   = e.a;
      m_wd   = e.d;
      last_g = g;
    end
    if (tx0 && in0_addr != AW'(ZR)) q0.push_back({in0_addr, in0_data});
    if (tx1 && in1_addr != AW'(ZR)) q1.push_back({in1_addr, in1_data});
    check("RegWrite", RegWrite, m_rw);
    check("WriteRegister", WriteRegister, m_wa);
    check("WriteData", WriteData, m_wd);
    check("busy", busy, (q0.size() > 0) || (q1.size() > 0) || m_rw);
    if (RegWrite) begin
      rf_dut[WriteRegister] = WriteData;
      got_a.push_back(WriteRegister);
      got_d.push_back(WriteData);
      got_t.push_back(cyc);
    end
    if (tx0 && in0_addr != AW'(ZR)) rf_ideal[in0_addr] = in0_data;
    if (tx1 && in1_addr != AW'(ZR)) rf_ideal[in1_addr] = in1_data;
    if (tx0) in0_valid = 1'b0;
    if (tx1) in1_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n   = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    #1;
    check("rst_RegWrite", RegWrite, 1'b0);
    check("rst_WriteRegister", WriteRegister, 5'd0);
    check("rst_WriteData", WriteData, 64'd0);
    check("rst_busy", busy, 1'b0);
`ifdef REGWR_PENDING_EN
    check("rst_qry_pending", qry_pending, 1'b0);
`endif
    model_clear();
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_RegWrite", RegWrite, 1'b0);
    check("rst_rel_busy", busy, 1'b0);
  endtask

  task automatic drain();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (q0.size() == 0 && q1.size() == 0 && !m_rw) break;
      step();
    end
    check("drain_busy", busy, 1'b0);
  endtask

  // Stream n0 writes to b0.. on in0 and n1 writes to b1.. on in1
  task automatic run_streams(input int b0, input int n0, input int b1, input int n1);
    int i0 = 0;
    int i1 = 0;
    for (int c = 0; c < 60; c++) begin
      if (!in0_valid && i0 < n0) begin
        in0_valid = 1'b1; in0_addr = AW'(b0 + i0); in0_data = DW'(64'h1000 + i0); i0++;
      end
      if (!in1_valid && i1 < n1) begin
        in1_valid = 1'b1; in1_addr = AW'(b1 + i1); in1_data = DW'(64'h2000 + i1); i1++;
      end
      if (i0 == n0 && i1 == n1 && !in0_valid && !in1_valid) break;
      step();
    end
    check("stream_sent", {in0_valid, in1_valid}, 2'b00);
    drain();
  endtask

  initial begin
    int exp_sat[8];
    int k;
    exp_sat = '{1, 11, 2, 12, 3, 13, 4, 14};
    reset_n   = 1'b0;
    in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
    in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
`ifdef REGWR_PENDING_EN
    qry_addr  = 5'd7;
`endif
    for (int i = 0; i < 32; i++) begin rf_ideal[i] = '0; rf_dut[i] = '0; end
    model_clear();
    do_reset();

    // single write, latency and busy fall
    in0_valid = 1'b1; in0_addr = 5'd5; in0_data = 64'hDEAD;
    step();
    check("single_rw_e1", RegWrite, 1'b0);
    check("single_busy_e1", busy, 1'b1);
    step();
    check("single_rw_e2", RegWrite, 1'b1);
    check("single_wa_e2", WriteRegister, 5'd5);
    check("single_wd_e2", WriteData, 64'hDEAD);
    step();
    check("single_rw_e3", RegWrite, 1'b0);
    check("single_busy_e3", busy, 1'b0);

    // saturated contention from a fresh reset: 1,11,2,12,... with no gaps
    do_reset();
    got_a.delete(); got_d.delete(); got_t.delete();
    run_streams(1, 4, 11, 4);
    check("sat_len", got_a.size(), 8);
    if (got_a.size() == 8) begin
      for (int i = 0; i < 8; i++) check("sat_seq", got_a[i], exp_sat[i]);
      check("sat_nogap", got_t[7] - got_t[0], 7);
    end

    // backpressure: in0 pushes 3 writes against an in1 stream, order kept
    got_a.delete(); got_d.delete(); got_t.delete();
    run_streams(1, 3, 20, 4);
    k = 0;
    foreach (got_a[i]) begin
      if (got_a[i] < 5'd4) begin
        check("bp_addr", got_a[i], k + 1);
        check("bp_data", got_d[i], 64'h1000 + k);
        k++;
      end
    end
    check("bp_count", k, 3);

    // XZR drop: handshake completes, nothing reaches the port
    in1_valid = 1'b1; in1_addr = 5'd31; in1_data = 64'h1;
    step();
    check("xzr_taken", in1_valid, 1'b0);
    check("xzr_rw", RegWrite, 1'b0);
    check("xzr_busy", busy, 1'b0);
    step();
    check("xzr_rw2", RegWrite, 1'b0);
    check("xzr_busy2", busy, 1'b0);

    // WAW guard: both target r7 in the same cycle
    got_a.delete(); got_d.delete(); got_t.delete();
    in0_valid = 1'b1; in0_addr = 5'd7; in0_data = 64'hAAAA;
    in1_valid = 1'b1; in1_addr = 5'd7; in1_data = 64'hBBBB;
    for (int c = 0; c < 12 && (in0_valid || in1_valid); c++) step();
    drain();
    check("waw_len", got_d.size(), 2);
    if (got_d.size() == 2) begin
      check("waw_first", got_d[0], 64'hAAAA);
      check("waw_second", got_d[1], 64'hBBBB);
    end
    check("waw_final", rf_dut[7], 64'hBBBB);

    // reset mid-run with writes queued
    in0_valid = 1'b1; in0_addr = 5'd7; in0_data = 64'h77;
    in1_valid = 1'b1; in1_addr = 5'd9; in1_data = 64'h99;
    step();
    in0_valid = 1'b1; in0_addr = 5'd8; in0_data = 64'h88;
    step();
    check("mid_busy", busy, 1'b1);
`ifdef REGWR_PENDING_EN
    check("mid_qry_before", qry_pending, 1'b1);
`endif
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      check("mid_after_rw", RegWrite, 1'b0);
    end

    // randomized traffic, then compare register files
    for (int i = 0; i < 32; i++) begin rf_ideal[i] = '0; rf_dut[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      if (!in0_valid && $urandom_range(0, 2) != 0) begin
        in0_valid = 1'b1;
        in0_addr  = ($urandom_range(0, 9) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
        in0_data  = {$urandom(), $urandom()};
      end
      if (!in1_valid && $urandom_range(0, 2) != 0) begin
        in1_valid = 1'b1;
        in1_addr  = ($urandom_range(0, 9) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
        in1_data  = {$urandom(), $urandom()};
      end
`ifdef REGWR_PENDING_EN
      qry_addr = ($urandom_range(0, 7) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
`endif
      step();
    end
    drain();
    for (int i = 0; i < 32; i++) check("rf_final", rf_dut[i], rf_ideal[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
